apb_i2c_regbank: RTL and testbench
==================================

Name: apb_i2c_regbank

Overview:
- Parametrised APB slave register bank fronting the I2C master core.
- Successor to the fixed 8-bit APB/I2C signal bundle: adds configurable data width, APB wait states, TX/RX FIFOs, sticky status, error response and interrupt.
- Sits between the APB bus and the I2C byte engine, and exchanges bytes with the engine over valid/ready streams.

Parameters:
- DATA_W, 8: APB data and register width, ≥8; I2C payload is always the low 8 bits.
- ADDR_W, 8: APB address width.
- FIFO_DEPTH, 4: depth of each of TX and RX FIFO; power of 2, ≥2.
- WAIT_STATES, 0: extra access-phase cycles with pready low, 0..7.

Ports:
- pclk  in  1  single clock for APB and core side
- preset  in  1  synchronous active-high reset
- paddr  in  ADDR_W  APB address
- pselx  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  1=write
- pwdata  in  DATA_W  write data
- prdata  out  DATA_W  read data, valid when pready=1
- pready  out  1  transfer complete
- pslverr  out  1  error, valid when pready=1
- slave_address  out  7  target address from SADDR
- rw  out  1  1=read transfer
- start  out  1  one-cycle start pulse to core
- tx_data  out  8  TX FIFO head
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  core consumes tx_data
- rx_data  in  8  byte from core
- rx_valid  in  1  core offers rx_data
- rx_ready  out  1  RX FIFO not full
- core_busy  in  1  core transfer in progress
- core_done  in  1  one-cycle end-of-transfer pulse
- core_nack  in  1  one-cycle NACK pulse
- irq  out  1  level interrupt

Behaviour:
- Reset (synchronous, active-high preset):
  - Clears every register, both FIFOs and the wait counter on the first pclk edge where preset=1.
  - Output values: prdata=0, pready=0, pslverr=0, start=0, slave_address=0, rw=0, tx_valid=0, rx_ready=1, irq=0.
  - Reset mid-APB-access or mid-core-transfer aborts everything; FIFO contents are discarded.
- APB timing:
  - Setup phase: pselx=1, penable=0.
  - Access phase: pselx=1, penable=1. The wait counter loads WAIT_STATES on entry. pready=1 when the counter reaches 0, so pready rises WAIT_STATES cycles after penable (0 → same cycle).
  - Side effects (register write, FIFO push/pop, W1C) occur only on the pclk edge where pselx&penable&pready=1, exactly once per transfer.
  - prdata and pslverr are combinational from the registered state and are 0 when pready=0.
- Register map (byte offsets; unmapped offsets → pslverr=1, no effect, prdata=0):
  - 0x00 CTRL RW: [0] EN, [1] START (write-1 self-clearing, reads 0), [2] IRQ_EN.
  - 0x04 STATUS: [0] busy (core_busy), [1] tx_full, [2] tx_empty, [3] rx_full, [4] rx_empty, [5] NACK sticky W1C, [6] DONE sticky W1C, [7] OVF sticky W1C.
  - 0x08 SADDR RW: [6:0] slave_address, [7] rw.
  - 0x0C TXDATA WO: push pwdata[7:0]. Reads return 0 with no error.
  - 0x10 RXDATA RO: pop and return the head, zero-extended. Writes → pslverr.
  - 0x14 LEVEL RO: [7:0] tx count, [15:8] rx count, truncated to DATA_W.
- start:
  - Pulses 1 cycle after a START write when EN=1 and core_busy=0.
  - Otherwise the START write is dropped and returns no error.
- FIFO rules:
  - A push to a full TX FIFO, or rx_valid while the RX FIFO is full, drops the data and sets OVF. An APB TXDATA write to a full FIFO also returns pslverr=1.
  - A pop from an empty RX FIFO returns 0 with pslverr=1.
  - A full FIFO rejects a push even when a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-empty, non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Sticky bits:
  - core_done sets DONE; core_nack sets NACK.
  - If a set event and a W1C happen in the same cycle, the set wins.
- Interrupt: irq = IRQ_EN & (DONE | NACK | OVF), registered, so it rises 1 cycle after the flag.
- EN=0: the TX FIFO keeps its data but tx_valid is forced to 0.

Decomposition:
- Package i2c_apb_pkg: register offset constants, CTRL/STATUS bit-index constants, and a reg_offset_t typedef.
- Sub-module i2c_sync_fifo, with parameters W and DEPTH and ports push/pop/full/empty/count. It is instantiated twice, once for TX and once for RX.

Test Plan:
- Reset, then read every register with WAIT_STATES=2 → pready high 2 cycles after penable; all reads 0 except STATUS=0x14 (tx_empty, rx_empty).
- Write SADDR=0x A5, CTRL=0x03 → slave_address=0x25, rw=1, and a single start pulse 1 cycle after the access; CTRL then reads 0x01.
- Push 0x11, 0x22, 0x33, 0x44, then 0x55 into TXDATA (FIFO_DEPTH=4) → 5th write returns pslverr=1, OVF=1; the core drains 0x11..0x44 in order.
- Core drives rx_valid with 0xAB and 0xCD → RXDATA reads 0xAB then 0xCD; a 3rd read returns 0 with pslverr=1.
- IRQ_EN=1, pulse core_nack in the same cycle as a W1C of NACK → NACK stays 1 and irq=1 next cycle; a later W1C clears it and irq drops.
- Assert preset mid-access with 2 bytes in the TX FIFO → next cycle tx_valid=0, pready=0, and LEVEL reads 0 after reset.

Source files
------------

// File: rtl/i2c_apb_pkg.sv
// Register map and bit positions shared by the APB/I2C register bank and its bench.
package i2c_apb_pkg;

   typedef logic [7:0] reg_offset_t;

   localparam reg_offset_t OFF_CTRL   = 8'h00;
   localparam reg_offset_t OFF_STATUS = 8'h04;
   localparam reg_offset_t OFF_SADDR  = 8'h08;
   localparam reg_offset_t OFF_TXDATA = 8'h0C;
   localparam reg_offset_t OFF_RXDATA = 8'h10;
   localparam reg_offset_t OFF_LEVEL  = 8'h14;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_START  = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int ST_BUSY     = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_TX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_RX_EMPTY = 4;
   localparam int ST_NACK     = 5;
   localparam int ST_DONE     = 6;
   localparam int ST_OVF      = 7;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; a full FIFO refuses pushes
// even when a pop happens in the same cycle.
module i2c_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign pop_data  = r_mem[r_rd_ptr];
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/apb_i2c_regbank.sv
// APB slave register bank in front of the I2C byte engine: control/status,
// TX/RX byte FIFOs, sticky flags with W1C, programmable wait states and interrupt.
module apb_i2c_regbank
   import i2c_apb_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pselx,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic [6:0]        slave_address,
   output logic              rw,
   output logic              start,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              core_busy,
   input  logic              core_done,
   input  logic              core_nack,
   output logic              irq
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              r_armed;
   logic [2:0]        r_wait_cnt;
   logic              r_en;
   logic              r_irq_en;
   logic              r_start;
   logic              r_irq;
   logic [7:0]        r_saddr;
   logic [2:0]        r_sticky;

   logic              w_ready;
   logic              w_wr;
   logic              w_rd;
   logic              w_sel_ctrl;
   logic              w_sel_status;
   logic              w_sel_saddr;
   logic              w_sel_tx;
   logic              w_sel_rx;
   logic              w_sel_level;
   logic              w_tx_full;
   logic              w_tx_empty;
   logic              w_rx_full;
   logic              w_rx_empty;
   logic [CNT_W-1:0]  w_tx_count;
   logic [CNT_W-1:0]  w_rx_count;
   logic [7:0]        w_tx_head;
   logic [7:0]        w_rx_head;
   logic              w_tx_push;
   logic              w_tx_pop;
   logic              w_rx_push;
   logic              w_rx_pop;
   logic              w_ovf_evt;
   logic [2:0]        w_sticky_set;
   logic [2:0]        w_sticky_clr;
   logic [2:0]        w_sticky_next;
   logic [7:0]        w_ctrl;
   logic [7:0]        w_status;
   logic [DATA_W-1:0] w_rdata;
   logic              w_err;

   assign w_sel_ctrl   = (paddr == ADDR_W'(OFF_CTRL));
   assign w_sel_status = (paddr == ADDR_W'(OFF_STATUS));
   assign w_sel_saddr  = (paddr == ADDR_W'(OFF_SADDR));
   assign w_sel_tx     = (paddr == ADDR_W'(OFF_TXDATA));
   assign w_sel_rx     = (paddr == ADDR_W'(OFF_RXDATA));
   assign w_sel_level  = (paddr == ADDR_W'(OFF_LEVEL));

   // r_armed marks a setup phase seen since the last completion or reset,
   // so an access phase interrupted by reset never completes by itself.
   assign w_ready = pselx & penable & r_armed & (r_wait_cnt == 3'd0);
   assign w_wr    = w_ready & pwrite;
   assign w_rd    = w_ready & ~pwrite;

   assign w_tx_push = w_wr & w_sel_tx & ~w_tx_full;
   assign w_tx_pop  = tx_valid & tx_ready;
   assign w_rx_push = rx_valid & ~w_rx_full;
   assign w_rx_pop  = w_rd & w_sel_rx & ~w_rx_empty;
   assign w_ovf_evt = (w_wr & w_sel_tx & w_tx_full) | (rx_valid & w_rx_full);

   assign w_sticky_set = {w_ovf_evt, core_done, core_nack};
   assign w_sticky_clr = (w_wr & w_sel_status) ? pwdata[ST_OVF:ST_NACK] : 3'b000;

   // Sticky bit order is {OVF, DONE, NACK}; a set event beats a same-cycle clear.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
         assign w_sticky_next[gi] = w_sticky_set[gi] | (r_sticky[gi] & ~w_sticky_clr[gi]);
      end
   endgenerate

   i2c_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (pclk),
      .srst      (preset),
      .push      (w_tx_push),
      .push_data (pwdata[7:0]),
      .pop       (w_tx_pop),
      .pop_data  (w_tx_head),
      .full      (w_tx_full),
      .empty     (w_tx_empty),
      .count     (w_tx_count)
   );

   i2c_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (pclk),
      .srst      (preset),
      .push      (w_rx_push),
      .push_data (rx_data),
      .pop       (w_rx_pop),
      .pop_data  (w_rx_head),
      .full      (w_rx_full),
      .empty     (w_rx_empty),
      .count     (w_rx_count)
   );

   always_comb begin
      w_ctrl                   = '0;
      w_ctrl[CTRL_EN]          = r_en;
      w_ctrl[CTRL_IRQ_EN]      = r_irq_en;
      w_status                 = '0;
      w_status[ST_BUSY]        = core_busy;
      w_status[ST_TX_FULL]     = w_tx_full;
      w_status[ST_TX_EMPTY]    = w_tx_empty;
      w_status[ST_RX_FULL]     = w_rx_full;
      w_status[ST_RX_EMPTY]    = w_rx_empty;
      w_status[ST_NACK]        = r_sticky[0];
      w_status[ST_DONE]        = r_sticky[1];
      w_status[ST_OVF]         = r_sticky[2];
   end

   always_comb begin
      w_rdata = '0;
      w_err   = 1'b0;
      if (w_sel_ctrl) begin
         w_rdata = DATA_W'(w_ctrl);
      end else if (w_sel_status) begin
         w_rdata = DATA_W'(w_status);
      end else if (w_sel_saddr) begin
         w_rdata = DATA_W'(r_saddr);
      end else if (w_sel_tx) begin
         w_err = pwrite & w_tx_full;
      end else if (w_sel_rx) begin
         if (pwrite | w_rx_empty) w_err = 1'b1;
         else                     w_rdata = DATA_W'(w_rx_head);
      end else if (w_sel_level) begin
         if (pwrite) w_err = 1'b1;
         else        w_rdata = DATA_W'({8'(w_rx_count), 8'(w_tx_count)});
      end else begin
         w_err = 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         r_armed    <= 1'b0;
         r_wait_cnt <= '0;
         r_en       <= 1'b0;
         r_irq_en   <= 1'b0;
         r_start    <= 1'b0;
         r_saddr    <= '0;
         r_sticky   <= '0;
         r_irq      <= 1'b0;
      end else begin
         if (pselx & ~penable) begin
            r_armed    <= 1'b1;
            r_wait_cnt <= 3'(WAIT_STATES);
         end else if (w_ready) begin
            r_armed <= 1'b0;
         end else if (pselx & penable & (r_wait_cnt != 3'd0)) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
         end
         // START qualifies on the EN value carried by the same write.
         r_start <= w_wr & w_sel_ctrl & pwdata[CTRL_START] & pwdata[CTRL_EN] & ~core_busy;
         if (w_wr & w_sel_ctrl) begin
            r_en     <= pwdata[CTRL_EN];
            r_irq_en <= pwdata[CTRL_IRQ_EN];
         end
         if (w_wr & w_sel_saddr) begin
            r_saddr <= pwdata[7:0];
         end
         r_sticky <= w_sticky_next;
         r_irq    <= r_irq_en & (|r_sticky);
      end
   end

   assign pready        = w_ready;
   assign pslverr       = w_ready & w_err;
   assign prdata        = w_rd ? w_rdata : '0;
   assign slave_address = r_saddr[6:0];
   assign rw            = r_saddr[7];
   assign start         = r_start;
   assign irq           = r_irq;
   assign tx_data       = w_tx_head;
   assign tx_valid      = r_en & ~w_tx_empty;
   assign rx_ready      = ~w_rx_full;

endmodule

// File: tb/tb_apb_i2c_regbank.sv
// Table-driven APB transactions with a scoreboard, plus hand-written sequences
// for start pulse, FIFO drain/overflow, sticky/irq timing and mid-access reset.
module tb_apb_i2c_regbank;
   localparam int DATA_W      = 8;
   localparam int ADDR_W      = 8;
   localparam int FIFO_DEPTH  = 4;
   localparam int WAIT_STATES = 2;

   logic              pclk = 1'b0;
   logic              preset;
   logic [ADDR_W-1:0] paddr;
   logic              pselx;
   logic              penable;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;
   logic [6:0]        slave_address;
   logic              rw;
   logic              start;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              core_busy;
   logic              core_done;
   logic              core_nack;
   logic              irq;

   apb_i2c_regbank #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .WAIT_STATES(WAIT_STATES)
   ) dut (
      .pclk(pclk), .preset(preset), .paddr(paddr), .pselx(pselx), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .slave_address(slave_address), .rw(rw), .start(start), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .core_busy(core_busy), .core_done(core_done),
      .core_nack(core_nack), .irq(irq)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [7:0] addr;
      logic       wr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
      logic       exp_err;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] rd;
      logic       err;
      logic       chk_rd;
   } exp_t;

   vec_t       vtab[$];
   exp_t       exp_q[$];
   logic [7:0] tx_q[$];
   int         n_pass = 0;
   int         n_total = 0;
   int         start_cnt = 0;
   int         sc;

   always @(negedge pclk) begin
      if (start) start_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
   endfunction

   function automatic void row(logic [7:0] a, logic w, logic [7:0] d, logic [7:0] erd, logic eerr);
      vec_t v;
      v = '{a, w, d, erd, eerr};
      vtab.push_back(v);
   endfunction

   task automatic apb(input logic [7:0] a, input logic w, input logic [7:0] d, input logic nack_x,
                      output logic [7:0] rd, output logic er, output int wt);
      @(posedge pclk); #1;
      paddr = a; pwrite = w; pwdata = d; pselx = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      wt = 0;
      @(negedge pclk);
      while (!pready && wt < 20) begin
         wt++;
         @(negedge pclk);
      end
      rd = prdata;
      er = pslverr;
      if (nack_x) core_nack = 1'b1;
      @(posedge pclk); #1;
      core_nack = 1'b0;
      pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic do_apb(input logic [7:0] a, input logic w, input logic [7:0] d,
                         input logic [7:0] erd, input logic eerr, input logic nack_x);
      exp_t       e;
      logic [7:0] rd;
      logic       er;
      int         wt;
      e.name   = $sformatf("%s_%02h", w ? "wr" : "rd", a);
      e.rd     = erd;
      e.err    = eerr;
      e.chk_rd = ~w;
      exp_q.push_back(e);
      if (w && a == 8'h0C && !eerr) tx_q.push_back(d);
      apb(a, w, d, nack_x, rd, er, wt);
      $display("apb %s addr=0x%02h wdata=0x%02h rdata=0x%02h err=%0d waits=%0d",
               w ? "wr" : "rd", a, d, rd, er, wt);
      e = exp_q.pop_front();
      check({e.name, "_waits"}, wt, WAIT_STATES);
      if (e.chk_rd) check({e.name, "_rdata"}, rd, e.rd);
      check({e.name, "_err"}, er, e.err);
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         do_apb(vtab[i].addr, vtab[i].wr, vtab[i].wdata, vtab[i].exp_rd, vtab[i].exp_err, 1'b0);
      end
   endtask

   initial begin
      // rows 0-10: reset readback, error decode, SADDR
      row(8'h00, 0, 8'h00, 8'h00, 0);
      row(8'h04, 0, 8'h00, 8'h14, 0);
      row(8'h08, 0, 8'h00, 8'h00, 0);
      row(8'h0C, 0, 8'h00, 8'h00, 0);
      row(8'h10, 0, 8'h00, 8'h00, 1);
      row(8'h14, 0, 8'h00, 8'h00, 0);
      row(8'h18, 0, 8'h00, 8'h00, 1);
      row(8'h01, 0, 8'h00, 8'h00, 1);
      row(8'h10, 1, 8'h5A, 8'h00, 1);
      row(8'h08, 1, 8'hA5, 8'h00, 0);
      row(8'h08, 0, 8'h00, 8'hA5, 0);
      // rows 11-17: TX fill past full
      row(8'h0C, 1, 8'h11, 8'h00, 0);
      row(8'h0C, 1, 8'h22, 8'h00, 0);
      row(8'h0C, 1, 8'h33, 8'h00, 0);
      row(8'h0C, 1, 8'h44, 8'h00, 0);
      row(8'h0C, 1, 8'h55, 8'h00, 1);
      row(8'h04, 0, 8'h00, 8'h92, 0);
      row(8'h14, 0, 8'h00, 8'h04, 0);
      // rows 18-19: clear sticky flags
      row(8'h04, 1, 8'hE0, 8'h00, 0);
      row(8'h04, 0, 8'h00, 8'h14, 0);
      // rows 20-22: RX reads
      row(8'h10, 0, 8'h00, 8'hAB, 0);
      row(8'h10, 0, 8'h00, 8'hCD, 0);
      row(8'h10, 0, 8'h00, 8'h00, 1);
      // rows 23-24: after RX overflow
      row(8'h04, 0, 8'h00, 8'h8C, 0);
      row(8'h14, 0, 8'h00, 8'h00, 0);
      // rows 25-27: after mid-access reset
      row(8'h14, 0, 8'h00, 8'h00, 0);
      row(8'h04, 0, 8'h00, 8'h14, 0);
      row(8'h00, 0, 8'h00, 8'h00, 0);

      preset = 1'b1; paddr = '0; pselx = 0; penable = 0; pwrite = 0; pwdata = '0;
      tx_ready = 0; rx_data = '0; rx_valid = 0; core_busy = 0; core_done = 0; core_nack = 0;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      check("rst_prdata", prdata, 0);
      check("rst_pready", pready, 0);
      check("rst_pslverr", pslverr, 0);
      check("rst_start", start, 0);
      check("rst_saddr", slave_address, 0);
      check("rst_rw", rw, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_rx_ready", rx_ready, 1);
      check("rst_irq", irq, 0);
      @(posedge pclk); #1;
      preset = 1'b0;

      run_rows(0, 10);

      sc = start_cnt;
      do_apb(8'h00, 1, 8'h03, 8'h00, 0, 0);
      @(negedge pclk);
      check("start_pulse_hi", start, 1);
      @(negedge pclk);
      check("start_pulse_lo", start, 0);
      check("start_count", start_cnt - sc, 1);
      check("slave_address", slave_address, 7'h25);
      check("rw", rw, 1);
      do_apb(8'h00, 0, 8'h00, 8'h01, 0, 0);

      core_busy = 1'b1;
      sc = start_cnt;
      do_apb(8'h00, 1, 8'h03, 8'h00, 0, 0);
      do_apb(8'h04, 0, 8'h00, 8'h15, 0, 0);
      repeat (2) @(negedge pclk);
      check("start_dropped_busy", start_cnt - sc, 0);
      core_busy = 1'b0;

      run_rows(11, 17);

      do_apb(8'h00, 1, 8'h00, 8'h00, 0, 0);
      @(negedge pclk);
      check("tx_valid_en0", tx_valid, 0);
      do_apb(8'h00, 1, 8'h01, 8'h00, 0, 0);
      @(negedge pclk);
      check("tx_valid_en1", tx_valid, 1);

      @(posedge pclk); #1;
      tx_ready = 1'b1;
      for (int c = 0; c < 20 && tx_q.size() > 0; c++) begin
         @(negedge pclk);
         if (tx_valid) begin
            logic [7:0] exp_b;
            exp_b = tx_q.pop_front();
            $display("core tx byte=0x%02h expected=0x%02h", tx_data, exp_b);
            check("tx_drain", tx_data, exp_b);
         end
      end
      @(posedge pclk); #1;
      tx_ready = 1'b0;
      @(negedge pclk);
      check("tx_drain_left", tx_q.size(), 0);
      check("tx_valid_drained", tx_valid, 0);

      run_rows(18, 19);

      @(posedge pclk); #1;
      rx_data = 8'hAB; rx_valid = 1'b1;
      @(negedge pclk);
      check("rx_ready_open", rx_ready, 1);
      @(posedge pclk); #1;
      rx_data = 8'hCD;
      @(posedge pclk); #1;
      rx_valid = 1'b0; rx_data = '0;
      $display("core rx pushed 0xAB 0xCD");

      run_rows(20, 22);

      do_apb(8'h00, 1, 8'h05, 8'h00, 0, 0);
      @(posedge pclk); #1;
      core_nack = 1'b1;
      @(posedge pclk); #1;
      core_nack = 1'b0;
      @(negedge pclk);
      check("irq_latency_lo", irq, 0);
      @(negedge pclk);
      check("irq_latency_hi", irq, 1);
      do_apb(8'h04, 1, 8'h20, 8'h00, 0, 1);
      @(negedge pclk);
      check("irq_set_wins", irq, 1);
      do_apb(8'h04, 0, 8'h00, 8'h34, 0, 0);
      do_apb(8'h04, 1, 8'h20, 8'h00, 0, 0);
      @(negedge pclk);
      @(negedge pclk);
      check("irq_cleared", irq, 0);
      do_apb(8'h04, 0, 8'h00, 8'h14, 0, 0);
      @(posedge pclk); #1;
      core_done = 1'b1;
      @(posedge pclk); #1;
      core_done = 1'b0;
      do_apb(8'h04, 0, 8'h00, 8'h54, 0, 0);
      do_apb(8'h04, 1, 8'h40, 8'h00, 0, 0);

      for (int i = 0; i < 5; i++) begin
         @(posedge pclk); #1;
         rx_data = 8'h90 + 8'(i); rx_valid = 1'b1;
         @(negedge pclk);
         if (i == 4) check("rx_ready_full", rx_ready, 0);
      end
      @(posedge pclk); #1;
      rx_valid = 1'b0;
      $display("core rx pushed 5 bytes into depth-4 fifo");
      run_rows(23, 24);
      @(negedge pclk);
      check("irq_ovf", irq, 1);

      do_apb(8'h0C, 1, 8'h66, 8'h00, 0, 0);
      do_apb(8'h0C, 1, 8'h77, 8'h00, 0, 0);
      @(negedge pclk);
      check("tx_valid_prereset", tx_valid, 1);
      @(posedge pclk); #1;
      paddr = 8'h14; pwrite = 1'b0; pselx = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b0;
      @(negedge pclk);
      check("midrst_tx_valid", tx_valid, 0);
      check("midrst_pready", pready, 0);
      check("midrst_irq", irq, 0);
      @(posedge pclk); #1;
      pselx = 1'b0; penable = 1'b0;
      tx_q.delete();
      $display("reset applied mid-access");
      run_rows(25, 27);
      check("post_rst_rx_ready", rx_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
